midi_in_receiver: RTL and testbench

//  Serial receiver for one MIDI input: 31250 baud, 8N1, idle-high, LSB first.

---
 rtl/midi_in_receiver.sv | 127 ++++++++++++
 tb/tb_midi_in_receiver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/midi_in_receiver.sv
// MIDI serial input receiver: 8N1, LSB first, idle-high line oversampled on sys_clk.
// Each good frame updates data_rx/is_command and pulses new_byte_strobe for one cycle.
module midi_in_receiver #(
  parameter int BYTE_W          = 8,
  parameter int MIDI_BAUD       = 31250,
  parameter int MIDI_FRAME_SIZE = 10,
  parameter int SYSCLK_F        = 48000000
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              MIDI_IN,
  output logic [BYTE_W-1:0] data_rx,
  output logic              is_command,
  output logic              new_byte_strobe
);

  localparam int CLKS_PER_BIT = SYSCLK_F / MIDI_BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
  localparam int DATA_BITS    = MIDI_FRAME_SIZE - 2;
  localparam int BIT_W        = $clog2(MIDI_FRAME_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         sync_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;
  logic [BYTE_W-1:0]  data_q, data_d;
  logic               cmd_q, cmd_d;
  logic               stb_q, stb_d;
  logic               line;

  // Two-flop synchronizer, resets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], MIDI_IN};
  end

  assign line = sync_q[1];

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      cmd_q   <= 1'b0;
      stb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      stb_q   <= stb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    cmd_d   = cmd_q;
    stb_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!line) state_d = START;
      end
      START: begin
        // Re-check the start bit at its centre; a short low pulse is dropped here.
        if (cnt_q == CNT_W'(HALF_BIT - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = line ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[BYTE_W-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_W'(DATA_BITS - 1)) state_d = STOP;
        end
      end
      STOP: begin
        // Leave at stop-bit centre so a following start bit with no gap is caught.
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (line) begin
            data_d  = shift_q;
            cmd_d   = shift_q[BYTE_W-1];
            stb_d   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (line) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign data_rx         = data_q;
  assign is_command      = cmd_q;
  assign new_byte_strobe = stb_q;

endmodule

// File: tb/tb_midi_in_receiver.sv
// Bench for midi_in_receiver: frames driven on the serial line, expected bytes and
// strobe times kept in a queue and checked every cycle against the DUT outputs.
module tb_midi_in_receiver;

  localparam int SYSCLK_F = 4000000;
  localparam int BAUD     = 31250;
  localparam int CPB      = SYSCLK_F / BAUD;
  localparam int HALF     = CPB / 2;
  localparam int LAT      = HALF + 9 * CPB + 2;
  localparam int TOL      = 3;

  logic       sys_clk = 1'b0;
  logic       rst_n   = 1'b0;
  logic       MIDI_IN = 1'b1;
  logic [7:0] data_rx;
  logic       is_command;
  logic       new_byte_strobe;

  always #5 sys_clk = ~sys_clk;

  midi_in_receiver #(
    .BYTE_W(8), .MIDI_BAUD(BAUD), .MIDI_FRAME_SIZE(10), .SYSCLK_F(SYSCLK_F)
  ) dut (
    .sys_clk(sys_clk),
    .rst_n(rst_n),
    .MIDI_IN(MIDI_IN),
    .data_rx(data_rx),
    .is_command(is_command),
    .new_byte_strobe(new_byte_strobe)
  );

  typedef struct {
    logic [7:0] b;
    int         due;
  } exp_t;

  exp_t       pend[$];
  logic [7:0] m_data = 8'h00;
  logic       m_cmd  = 1'b0;
  int         cyc = 0;
  int         ntests = 0;
  int         nfail = 0;
  int         nstrobe = 0;
  int         last_lat = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    ntests++;
    if (act !== expv) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  initial forever begin
    @(posedge sys_clk);
    cyc <= cyc + 1;
  end

  // Per-cycle comparison against the queued expectations.
  initial forever begin
    exp_t e;
    @(negedge sys_clk);
    if (pend.size() > 0 && cyc > pend[0].due + TOL && new_byte_strobe !== 1'b1) begin
      ntests++;
      nfail++;
      $display("FAIL strobe_timeout: no strobe for byte %0h due at cycle %0d, now %0d",
               pend[0].b, pend[0].due, cyc);
      void'(pend.pop_front());
    end
    if (new_byte_strobe === 1'b1) begin
      nstrobe++;
      ntests++;
      if (pend.size() == 0) begin
        nfail++;
        $display("FAIL spurious_strobe: strobe at cycle %0d with no frame expected", cyc);
      end else begin
        e = pend.pop_front();
        last_lat = cyc - e.due + LAT;
        if (cyc < e.due - TOL || cyc > e.due + TOL) begin
          nfail++;
          $display("FAIL strobe_time: strobe at cycle %0d, required %0d +/- %0d", cyc, e.due, TOL);
        end
        m_data = e.b;
        m_cmd  = e.b[7];
      end
    end else begin
      check("strobe_level", {31'd0, new_byte_strobe}, 32'd0);
    end
    check("data_rx", {24'd0, data_rx}, {24'd0, m_data});
    check("is_command", {31'd0, is_command}, {31'd0, m_cmd});
  end

  task automatic send(input logic [7:0] b, input logic stop, input bit good);
    exp_t e;
    if (good) begin
      e.b   = b;
      e.due = cyc + 1 + LAT;
      pend.push_back(e);
    end
    MIDI_IN = 1'b0;
    repeat (CPB) @(posedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      MIDI_IN = b[i];
      repeat (CPB) @(posedge sys_clk);
    end
    MIDI_IN = stop;
    repeat (CPB) @(posedge sys_clk);
    MIDI_IN = 1'b1;
  endtask

  task automatic idle(input int n);
    MIDI_IN = 1'b1;
    repeat (n) @(posedge sys_clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 3 * LAT && pend.size() > 0; i++) @(posedge sys_clk);
    check("drain_empty", pend.size(), 0);
  endtask

  initial begin
    int s0;
    int ngood;
    logic [7:0] rb;
    rst_n   = 1'b0;
    MIDI_IN = 1'b1;
    repeat (5) @(posedge sys_clk);
    check("rst_data", {24'd0, data_rx}, 32'h0);
    check("rst_cmd", {31'd0, is_command}, 32'h0);
    check("rst_strobe", {31'd0, new_byte_strobe}, 32'h0);
    rst_n = 1'b1;
    idle(10);

    // Single status byte
    s0 = nstrobe;
    send(8'h90, 1'b1, 1'b1);
    idle(20);
    drain();
    check("t1_count", nstrobe - s0, 1);
    check("t1_data", {24'd0, data_rx}, 32'h90);
    check("t1_cmd", {31'd0, is_command}, 32'h1);
    check("t1_latency", (last_lat >= 1215 && last_lat <= 1221) ? 32'd1 : 32'd0, 32'd1);

    // Back-to-back data bytes, no idle gap
    s0 = nstrobe;
    send(8'h3C, 1'b1, 1'b1);
    send(8'h7F, 1'b1, 1'b1);
    idle(20);
    drain();
    check("t2_count", nstrobe - s0, 2);
    check("t2_data", {24'd0, data_rx}, 32'h7F);
    check("t2_cmd", {31'd0, is_command}, 32'h0);

    // Short low glitch on an idle line
    s0 = nstrobe;
    MIDI_IN = 1'b0;
    repeat (HALF - 24) @(posedge sys_clk);
    idle(3 * CPB);
    check("t3_count", nstrobe - s0, 0);
    check("t3_data", {24'd0, data_rx}, 32'h7F);

    // Framing error, then a good status byte
    s0 = nstrobe;
    send(8'h80, 1'b0, 1'b0);
    idle(200);
    check("t4_bad_count", nstrobe - s0, 0);
    check("t4_bad_data", {24'd0, data_rx}, 32'h7F);
    send(8'hB0, 1'b1, 1'b1);
    idle(20);
    drain();
    check("t4_count", nstrobe - s0, 1);
    check("t4_data", {24'd0, data_rx}, 32'hB0);
    check("t4_cmd", {31'd0, is_command}, 32'h1);

    // Reset in the middle of a 0xFF frame
    s0 = nstrobe;
    MIDI_IN = 1'b0;
    repeat (CPB) @(posedge sys_clk);
    MIDI_IN = 1'b1;
    repeat (4 * CPB) @(posedge sys_clk);
    rst_n  = 1'b0;
    m_data = 8'h00;
    m_cmd  = 1'b0;
    pend.delete();
    repeat (3) @(posedge sys_clk);
    check("t5_rst_data", {24'd0, data_rx}, 32'h0);
    check("t5_rst_cmd", {31'd0, is_command}, 32'h0);
    rst_n = 1'b1;
    idle(6 * CPB);
    check("t5_abort_count", nstrobe - s0, 0);
    send(8'h45, 1'b1, 1'b1);
    idle(20);
    drain();
    check("t5_count", nstrobe - s0, 1);
    check("t5_data", {24'd0, data_rx}, 32'h45);
    check("t5_cmd", {31'd0, is_command}, 32'h0);

    // Random bytes, random gaps (often zero), occasional framing errors
    s0    = nstrobe;
    ngood = 0;
    for (int k = 0; k < 18; k++) begin
      rb = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        send(rb, 1'b0, 1'b0);
        idle($urandom_range(5, 100));
      end else begin
        send(rb, 1'b1, 1'b1);
        ngood++;
        if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 200));
      end
    end
    idle(20);
    drain();
    check("t6_count", nstrobe - s0, ngood);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
